// File: rtl/vram_write_arbiter.sv
// Round-robin writeback arbiter onto the VRAM write ports.
// Grants up to N_WRITE address-distinct writes per cycle, registered onto w_out.
module vram_write_arbiter #(
    parameter  int WIDTH      = 16,
    parameter  int DEPTH      = 64,
    parameter  int N_WRITE    = 3,
    parameter  int N_REQ      = 5,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int PORT_W     = 1 + ADDR_WIDTH + WIDTH,
    localparam int PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*WIDTH-1:0]        req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          flush,
    output logic [N_WRITE*PORT_W-1:0]     w_out,
    output logic                          busy
);

    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          ptr_nxt;
    logic [N_REQ-1:0]          grant;
    logic [N_WRITE*PORT_W-1:0] port_nxt;
    logic [ADDR_WIDTH-1:0]     used_addr [N_WRITE];
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic [WIDTH-1:0]          cur_data;
    logic                      ok;
    int                        cnt;
    int                        idx;
    int                        last;

    // Circular scan from ptr; address-colliding requesters are skipped, not blocking.
    always_comb begin
        grant    = '0;
        port_nxt = '0;
        ptr_nxt  = ptr;
        cnt      = 0;
        idx      = 0;
        last     = 0;
        ok       = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        for (int j = 0; j < N_WRITE; j++) begin
            used_addr[j] = '0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            idx      = (int'(ptr) + k) % N_REQ;
            cur_addr = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            cur_data = req_data[idx*WIDTH +: WIDTH];
            ok = req_valid[idx] && (cnt < N_WRITE) && !flush && !reset;
            for (int j = 0; j < N_WRITE; j++) begin
                if (j < cnt && used_addr[j] == cur_addr) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                grant[idx]     = 1'b1;
                used_addr[cnt] = cur_addr;
                port_nxt[cnt*PORT_W +: PORT_W] = {1'b1, cur_addr, cur_data};
                cnt  = cnt + 1;
                last = idx;
            end
        end
        if (|grant) begin
            ptr_nxt = PTR_W'((last + 1) % N_REQ);
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            w_out <= '0;
            busy  <= 1'b0;
        end else if (flush) begin
            ptr   <= '0;
            w_out <= '0;
            busy  <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            w_out <= port_nxt;
            busy  <= |grant;
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed table plus randomized reference-model bench for vram_write_arbiter.
module tb_vram_write_arbiter;

    localparam int NR = 5;
    localparam int NW = 3;
    localparam int AW = 6;
    localparam int W  = 16;
    localparam int PW = 1 + AW + W;
    localparam int OW = NW * PW;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*W-1:0]  req_data;
    logic [OW-1:0] w_out;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    vram_write_arbiter #(
        .WIDTH(W), .DEPTH(64), .N_WRITE(NW), .N_REQ(NR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .flush(flush),
        .w_out(w_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          fl;
        logic [NR-1:0] v;
        logic [NR*AW-1:0] a;
        logic [W-1:0]  db;
        logic [NR-1:0] rdy;
        int            p0;
        int            p1;
        int            p2;
        logic [2:0]    ptr;
    } vec_t;

    vec_t tab[$];

    function automatic logic [NR*AW-1:0] pa(int a0, int a1, int a2,
                                            int a3, int a4);
        return {6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    task automatic add(logic rst, logic fl, logic [NR-1:0] v,
                       logic [NR*AW-1:0] a, logic [W-1:0] db,
                       logic [NR-1:0] rdy, int p0, int p1, int p2,
                       logic [2:0] ptr);
        vec_t t;
        t.rst = rst; t.fl = fl; t.v = v; t.a = a; t.db = db;
        t.rdy = rdy; t.p0 = p0; t.p1 = p1; t.p2 = p2; t.ptr = ptr;
        tab.push_back(t);
    endtask

    task automatic check(string name, logic [OW-1:0] act,
                         logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] port_of(int r);
        return {1'b1, req_addr[r*AW +: AW], req_data[r*W +: W]};
    endfunction

    // Reference model state and scan
    int mptr;

    task automatic model(output logic [NR-1:0] rdy,
                         output logic [OW-1:0] ew, output int nptr);
        logic [AW-1:0] used [NW];
        logic [AW-1:0] a;
        int cnt;
        int r;
        bit dup;
        rdy  = '0;
        ew   = '0;
        cnt  = 0;
        nptr = mptr;
        for (int j = 0; j < NW; j++) used[j] = '0;
        if (reset || flush) begin
            nptr = 0;
            return;
        end
        for (int k = 0; k < NR; k++) begin
            r = (mptr + k) % NR;
            a = req_addr[r*AW +: AW];
            dup = 0;
            for (int j = 0; j < cnt; j++) if (used[j] == a) dup = 1;
            if (req_valid[r] && cnt < NW && !dup) begin
                rdy[r]   = 1'b1;
                used[cnt] = a;
                ew[cnt*PW +: PW] = port_of(r);
                cnt++;
                nptr = (r + 1) % NR;
            end
        end
    endtask

    logic [OW-1:0] ew;
    logic [NR-1:0] erdy;
    logic [NR-1:0] hs;
    int            np;
    int            pl [3];
    logic          rv [NR];
    logic [AW-1:0] ra [NR];
    logic [W-1:0]  rd [NR];
    int            wait_c [NR];
    int            en_cnt;
    bit            dupf;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // rst fl valid addrs data-base ready ports ptr
        add(1, 0, 5'b11111, pa(10,11,12,13,14), 16'h1000, 5'b00000, -1,-1,-1, 0);
        add(0, 0, 5'b11111, pa(10,11,12,13,14), 16'h1000, 5'b00111,  0, 1, 2, 3);
        add(0, 0, 5'b11111, pa(10,11,12,13,14), 16'h2000, 5'b11001,  3, 4, 0, 1);
        add(0, 0, 5'b11111, pa(10,11,12,13,14), 16'h3000, 5'b01110,  1, 2, 3, 4);
        add(0, 1, 5'b11111, pa(10,11,12,13,14), 16'h4000, 5'b00000, -1,-1,-1, 0);
        add(0, 0, 5'b00111, pa(7,7,9,0,0),      16'h5000, 5'b00101,  0, 2,-1, 3);
        add(0, 0, 5'b00010, pa(0,7,0,0,0),      16'h5000, 5'b00010,  1,-1,-1, 2);
        add(0, 0, 5'b10000, pa(0,0,0,0,5),      16'hBEEB, 5'b10000,  4,-1,-1, 0);
        add(0, 0, 5'b00000, pa(1,2,3,4,5),      16'h6000, 5'b00000, -1,-1,-1, 0);
        add(0, 0, 5'b11111, pa(3,3,3,3,3),      16'h7000, 5'b00001,  0,-1,-1, 1);
        add(0, 0, 5'b11111, pa(3,3,3,3,3),      16'h7100, 5'b00010,  1,-1,-1, 2);
        add(0, 0, 5'b11111, pa(1,2,2,1,6),      16'h8000, 5'b11100,  2, 3, 4, 0);
        add(1, 0, 5'b11111, pa(10,11,12,13,14), 16'h9000, 5'b00000, -1,-1,-1, 0);
        add(1, 1, 5'b11111, pa(10,11,12,13,14), 16'h9000, 5'b00000, -1,-1,-1, 0);
        add(0, 0, 5'b11111, pa(10,11,12,13,14), 16'hA000, 5'b00111,  0, 1, 2, 3);
        add(0, 1, 5'b00010, pa(0,20,0,0,0),     16'hB000, 5'b00000, -1,-1,-1, 0);

        for (int n = 0; n < tab.size(); n++) begin
            @(negedge clk);
            reset     = tab[n].rst;
            flush     = tab[n].fl;
            req_valid = tab[n].v;
            req_addr  = tab[n].a;
            for (int i = 0; i < NR; i++)
                req_data[i*W +: W] = tab[n].db + W'(i);
            #1;
            check($sformatf("v%0d_ready", n), OW'(req_ready), OW'(tab[n].rdy));
            ew = '0;
            pl[0] = tab[n].p0; pl[1] = tab[n].p1; pl[2] = tab[n].p2;
            for (int k = 0; k < NW; k++)
                if (pl[k] >= 0) ew[k*PW +: PW] = port_of(pl[k]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wout", n), w_out, ew);
            check($sformatf("v%0d_busy", n), OW'(busy),
                  OW'(pl[0] >= 0));
            check($sformatf("v%0d_ptr", n), OW'(dut.ptr), OW'(tab[n].ptr));
        end

        // Random traffic: phase 0 dense conflicting addresses,
        // phase 1 per-requester distinct addresses for the starvation bound.
        mptr = 0;
        for (int i = 0; i < NR; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rd[i] = '0; wait_c[i] = 0;
        end
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                reset = (c == 0) || ($urandom_range(0, 31) == 0);
                flush = ($urandom_range(0, 15) == 0);
                for (int i = 0; i < NR; i++) begin
                    req_valid[i]        = rv[i];
                    req_addr[i*AW +: AW] = ra[i];
                    req_data[i*W +: W]   = rd[i];
                end
                #1;
                model(erdy, ew, np);
                check("rnd_ready", OW'(req_ready), OW'(erdy));
                hs = req_valid & req_ready;
                if (ph == 1) begin
                    for (int i = 0; i < NR; i++) begin
                        if (req_valid[i] && !req_ready[i] && !flush && !reset)
                            wait_c[i]++;
                        else
                            wait_c[i] = 0;
                        if (wait_c[i] > NR) begin
                            checks++;
                            failures++;
                            $display("FAIL starve req=%0d waited=%0d limit=%0d",
                                     i, wait_c[i], NR);
                            wait_c[i] = 0;
                        end
                    end
                end
                @(posedge clk);
                #1;
                check("rnd_wout", w_out, ew);
                check("rnd_busy", OW'(busy), OW'(|erdy));
                en_cnt = 0;
                dupf   = 0;
                for (int p = 0; p < NW; p++) begin
                    if (w_out[p*PW + PW - 1]) en_cnt++;
                    for (int q = p + 1; q < NW; q++)
                        if (w_out[p*PW + PW - 1] && w_out[q*PW + PW - 1] &&
                            w_out[p*PW + W +: AW] == w_out[q*PW + W +: AW])
                            dupf = 1;
                end
                check("rnd_dup_addr", OW'(dupf), OW'(0));
                check("rnd_en_count", OW'(en_cnt), OW'($countones(hs)));
                mptr = np;
                for (int i = 0; i < NR; i++) begin
                    if (hs[i] || !rv[i]) begin
                        rv[i] = ($urandom_range(0, 3) != 0);
                        if (ph == 0)
                            ra[i] = AW'($urandom_range(0, 7));
                        else
                            ra[i] = {3'(i), 3'($urandom_range(0, 7))};
                        rd[i] = W'($urandom);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
